// File: rtl/token_access_arbiter.sv
// Round-robin arbiter for the token-authenticated P/Q time-data register path.
// Optional audit outputs (last_user, write_count) when TOKEN_ACCESS_ARBITER_AUDIT_EN is defined.
module token_access_arbiter #(
    parameter int NUM_USERS   = 4,
    parameter int TOKEN_W     = 3,
    parameter int DATA_W      = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 16,
    parameter int TIMEOUT     = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [TOKEN_W-1:0]             system_token,
    input  logic [NUM_USERS-1:0]           request,
    input  logic [NUM_USERS-1:0]           confirm,
    input  logic [NUM_USERS*TOKEN_W-1:0]   user_token,
    input  logic [NUM_USERS*DATA_W-1:0]    time_data,
    output logic [NUM_USERS-1:0]           grant,
    output logic                           busy,
    output logic                           auth_fail,
    output logic [NUM_USERS-1:0]           locked,
    output logic [DATA_W-1:0]              data_P,
    output logic [DATA_W-1:0]              data_Q
`ifdef TOKEN_ACCESS_ARBITER_AUDIT_EN
    ,
    output logic [$clog2(NUM_USERS)-1:0]   last_user,
    output logic [15:0]                    write_count
`endif
);

    localparam int PTR_W  = $clog2(NUM_USERS);
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_AUTH = 2'b01,
        ST_DATA = 2'b10
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_USERS-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 auth_fail_q, auth_fail_d;
    logic [DATA_W-1:0]    data_p_q, data_p_d;
    logic [DATA_W-1:0]    data_q_q, data_q_d;

    logic [NUM_USERS-1:0] lock_vec;
    logic [NUM_USERS-1:0] eligible;
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     cand_k;
    logic                 found;
    logic [PTR_W-1:0]     next_ptr;
    logic                 req_g;
    logic                 conf_g;
    logic                 tok_ok;
    logic [DATA_W-1:0]    data_g;
    logic                 rel_grant;
    logic                 pass_evt;
    logic                 fail_evt;
    logic                 write_evt;

    assign eligible = request & ~lock_vec;
    assign req_g    = request[owner_q];
    assign conf_g   = confirm[owner_q];
    assign tok_ok   = (user_token[int'(owner_q)*TOKEN_W +: TOKEN_W] == system_token);
    assign data_g   = time_data[int'(owner_q)*DATA_W +: DATA_W];
    assign next_ptr = (owner_q == PTR_W'(NUM_USERS - 1)) ? '0 : owner_q + PTR_W'(1);

    // Rotating priority search starting at rr_ptr
    always_comb begin
        found  = 1'b0;
        cand   = '0;
        cand_k = '0;
        for (int k = 0; k < NUM_USERS; k++) begin
            cand_k = PTR_W'((int'(rr_ptr_q) + k) % NUM_USERS);
            if (!found && eligible[cand_k]) begin
                found = 1'b1;
                cand  = cand_k;
            end
        end
    end

    // Per-user fail counter and lockout timer
    generate
        for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_user
            logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
            logic [LOCK_W-1:0] lock_timer_q, lock_timer_d;
            logic              is_owner;
            logic              lock_set;

            assign is_owner     = (owner_q == PTR_W'(gi));
            assign lock_vec[gi] = (lock_timer_q != '0);

            always_comb begin
                fail_cnt_d   = fail_cnt_q;
                lock_set     = 1'b0;
                lock_timer_d = lock_timer_q;
                if (is_owner && pass_evt) begin
                    fail_cnt_d = '0;
                end else if (is_owner && fail_evt) begin
                    if (fail_cnt_q == FAIL_W'(MAX_FAIL - 1)) begin
                        fail_cnt_d = '0;
                        lock_set   = 1'b1;
                    end else begin
                        fail_cnt_d = fail_cnt_q + FAIL_W'(1);
                    end
                end
                if (lock_set) begin
                    lock_timer_d = LOCK_W'(LOCK_CYCLES);
                end else if (lock_timer_q != '0) begin
                    lock_timer_d = lock_timer_q - LOCK_W'(1);
                end
            end

            always_ff @(posedge clock) begin
                if (reset) begin
                    fail_cnt_q   <= '0;
                    lock_timer_q <= '0;
                end else begin
                    fail_cnt_q   <= fail_cnt_d;
                    lock_timer_q <= lock_timer_d;
                end
            end
        end
    endgenerate

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_q       <= '0;
            auth_fail_q <= 1'b0;
            data_p_q    <= '0;
            data_q_q    <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_q       <= tmo_d;
            auth_fail_q <= auth_fail_d;
            data_p_q    <= data_p_d;
            data_q_q    <= data_q_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_d       = tmo_q;
        auth_fail_d = 1'b0;
        data_p_d    = data_p_q;
        data_q_d    = data_q_q;
        rel_grant   = 1'b0;
        pass_evt    = 1'b0;
        fail_evt    = 1'b0;
        write_evt   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (found) begin
                    owner_d = cand;
                    grant_d = NUM_USERS'(1) << cand;
                    state_d = ST_AUTH;
                    tmo_d   = '0;
                end
            end
            ST_AUTH: begin
                if (!req_g) begin
                    rel_grant = 1'b1;
                end else if (conf_g) begin
                    if (tok_ok) begin
                        state_d  = ST_DATA;
                        tmo_d    = '0;
                        pass_evt = 1'b1;
                    end else begin
                        auth_fail_d = 1'b1;
                        fail_evt    = 1'b1;
                        rel_grant   = 1'b1;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    rel_grant = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_DATA: begin
                if (!req_g) begin
                    rel_grant = 1'b1;
                end else if (conf_g) begin
                    data_q_d  = data_p_q;
                    data_p_d  = data_g;
                    write_evt = 1'b1;
                    rel_grant = 1'b1;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    rel_grant = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                tmo_d   = '0;
            end
        endcase

        if (rel_grant) begin
            grant_d  = '0;
            state_d  = ST_IDLE;
            tmo_d    = '0;
            rr_ptr_d = next_ptr;
        end
    end

    // Outputs
    always_comb begin
        grant     = grant_q;
        busy      = (state_q != ST_IDLE);
        auth_fail = auth_fail_q;
        locked    = lock_vec;
        data_P    = data_p_q;
        data_Q    = data_q_q;
    end

`ifdef TOKEN_ACCESS_ARBITER_AUDIT_EN
    logic [PTR_W-1:0] last_user_q, last_user_d;
    logic [15:0]      write_count_q, write_count_d;

    always_comb begin
        last_user_d   = last_user_q;
        write_count_d = write_count_q;
        if (write_evt) begin
            last_user_d   = owner_q;
            write_count_d = write_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            last_user_q   <= '0;
            write_count_q <= '0;
        end else begin
            last_user_q   <= last_user_d;
            write_count_q <= write_count_d;
        end
    end

    assign last_user   = last_user_q;
    assign write_count = write_count_q;
`endif

endmodule
